// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the RAM geometry, the halt opcode and the {pc, instr} entry type,
// plus small PC helpers used by the fetch unit.
package fetch_pkg;

  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int MEM_WORDS = 512;

  localparam logic [4:0] HALT_OPCODE = 5'b11011;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  // True when the instruction carries the halt opcode in its top five bits.
  function automatic logic is_halt(input logic [DATA_W-1:0] word);
    return (word[31:27] == HALT_OPCODE);
  endfunction

  // Sequential successor of a PC, wrapping silently past the last program word.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    if (32'(pc) == 32'(MEM_WORDS - 1)) begin
      return {ADDR_W{1'b0}};
    end else begin
      return pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Redirect targets outside the program image restart at word 0.
  function automatic logic [ADDR_W-1:0] legal_pc(input logic [ADDR_W-1:0] pc);
    if (32'(pc) >= 32'(MEM_WORDS)) begin
      return {ADDR_W{1'b0}};
    end else begin
      return pc;
    end
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle of the fetch stage: the instruction RAM read port (indx/instr)
// and the valid/ready handshake toward decode.
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic [ADDR_W-1:0] indx;
  logic [DATA_W-1:0] instr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;

  // Fetch unit side.
  modport master (
    output indx,
    input  instr,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  // RAM / decode side.
  modport slave (
    input  indx,
    output instr,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );

endinterface

// File: rtl/instr_fetch_unit_buffer.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO of {pc, instr} entries.
// Flush empties the buffer in one cycle; the head reads as zero when empty.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  // A push into a full buffer is only taken when the head leaves the same cycle.
  assign push_ok_s = push && (!full || pop) && !flush;
  assign pop_ok_s  = pop && !empty;

  // Pointer and occupancy bookkeeping; flush wins over push/pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage, cleared on reset so no stale word survives a restart.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_entry;
    end
  end

  // Head presentation: zero while empty, otherwise the oldest entry.
  always_comb begin
    head = '0;
    if (empty) begin
      head = '0;
    end else begin
      head = mem_r[rd_ptr_r];
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, indexes the instruction RAM, captures
// {pc, instr} pairs into a prefetch buffer and serves decode over valid/ready.
// Redirect reloads the PC and flushes the buffer.
// Optional halt-on-opcode support is built when FETCH_HALT_EN is defined;
// without it, halted is constant 0 and no opcode is inspected.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted,
  instr_fetch_unit_if.master bus
);

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_next_s;
  logic              halted_r;
  logic              pop_s;
  logic              push_s;
  logic              halt_hit_s;
  logic              full_s;
  logic              empty_s;
  fetch_entry_t      wr_entry_s;
  fetch_entry_t      head_s;

  // RAM index comes straight from the PC register; no input reaches it combinationally.
  assign bus.indx      = pc_r;
  assign bus.out_valid = !empty_s;
  assign bus.out_instr = head_s.instr;
  assign bus.out_pc    = head_s.pc;
  assign halted        = halted_r;

  assign pop_s  = !empty_s && bus.out_ready;
  assign push_s = en && !redirect_valid && !halted_r && (!full_s || pop_s);

  assign wr_entry_s.pc    = pc_r;
  assign wr_entry_s.instr = bus.instr;

`ifdef FETCH_HALT_EN
  assign halt_hit_s = push_s && is_halt(bus.instr);
`else
  assign halt_hit_s = 1'b0;
`endif

  // Next PC: redirect first, then sequential advance on a push, else hold.
  always_comb begin
    pc_next_s = pc_r;
    if (redirect_valid) begin
      pc_next_s = legal_pc(redirect_pc);
    end else if (push_s) begin
      pc_next_s = next_pc(pc_r);
    end else begin
      pc_next_s = pc_r;
    end
  end

  // Program counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  // Halt flag: set by a pushed halt word, cleared only by redirect or reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      halted_r <= 1'b0;
    end else if (redirect_valid) begin
      halted_r <= 1'b0;
    end else if (halt_hit_s) begin
      halted_r <= 1'b1;
    end else begin
      halted_r <= halted_r;
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push_s),
    .pop      (pop_s),
    .flush    (redirect_valid),
    .wr_entry (wr_entry_s),
    .head     (head_s),
    .full     (full_s),
    .empty    (empty_s)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. The RAM model returns 0x100 + index,
// optionally with a halt word at index 3 for the FETCH_HALT_EN build.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              en;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halted;
  bit                halt_word_en = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .DEPTH    (2),
    .RESET_PC (10'd0)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .en             (en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // Combinational instruction RAM model.
  always_comb begin
    if (halt_word_en && bus.indx == 10'd3) begin
      bus.instr = 32'hD800_0000;
    end else begin
      bus.instr = 32'h0000_0100 + 32'(bus.indx);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".pc"},    32'(bus.out_pc),    pc);
    chk({tag, ".instr"}, bus.out_instr,      ins);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".pc"},    32'(bus.out_pc),    32'd0);
    chk({tag, ".instr"}, bus.out_instr,      32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    en             = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 10'd0;
    bus.out_ready  = 1'b0;
    #12;
    chk_empty("reset");
    chk("reset.indx",   32'(bus.indx), 32'd0);
    chk("reset.halted", 32'(halted),   32'd0);

    // Streaming with decode always ready: first entry one edge after release.
    reset_n       = 1'b1;
    en            = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk_head("stream0", 32'd0, 32'h100);
    chk("stream0.indx", 32'(bus.indx), 32'd1);
    tick();
    chk_head("stream1", 32'd1, 32'h101);
    tick();
    chk_head("stream2", 32'd2, 32'h102);
    chk("stream2.indx", 32'(bus.indx), 32'd3);

    // Back-pressure from a fresh start: buffer fills at 2, PC stalls at 2.
    pulse_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_head("stall", 32'd0, 32'h100);
    chk("stall.indx", 32'(bus.indx), 32'd2);

    // Release: entries 0,1,2 in order, each exactly once.
    bus.out_ready = 1'b1;
    tick();
    chk_head("drain1", 32'd1, 32'h101);
    chk("drain1.indx", 32'(bus.indx), 32'd3);
    tick();
    chk_head("drain2", 32'd2, 32'h102);

    // Redirect while full; head 2 is consumed in the redirect cycle.
    redirect_valid = 1'b1;
    redirect_pc    = 10'h040;
    tick();
    chk_empty("redir.gap");
    chk("redir.indx", 32'(bus.indx), 32'h40);
    redirect_valid = 1'b0;
    tick();
    chk_head("redir0", 32'h40, 32'h140);
    tick();
    chk_head("redir1", 32'h41, 32'h141);

    // Wrap from the last program word back to 0.
    redirect_valid = 1'b1;
    redirect_pc    = 10'd511;
    tick();
    chk("wrap.indx511", 32'(bus.indx), 32'd511);
    redirect_valid = 1'b0;
    tick();
    chk_head("wrap511", 32'd511, 32'h2FF);
    chk("wrap.indx0", 32'(bus.indx), 32'd0);
    tick();
    chk_head("wrap0", 32'd0, 32'h100);
    chk("wrap.indx1", 32'(bus.indx), 32'd1);

    // Out-of-range redirect target restarts at 0.
    redirect_valid = 1'b1;
    redirect_pc    = 10'd600;
    tick();
    chk("oob.indx", 32'(bus.indx), 32'd0);
    chk_empty("oob");
    redirect_valid = 1'b0;

    // Fill to 2, then freeze with en=0 and drain with pops only.
    tick();
    chk_head("fill0", 32'd0, 32'h100);
    bus.out_ready = 1'b0;
    tick();
    en = 1'b0;
    tick();
    tick();
    chk_head("frozen", 32'd0, 32'h100);
    chk("frozen.indx", 32'(bus.indx), 32'd2);
    bus.out_ready = 1'b1;
    tick();
    chk_head("endrain", 32'd1, 32'h101);
    tick();
    chk_empty("endrained");
    chk("endrained.indx", 32'(bus.indx), 32'd2);
    chk("halted.default", 32'(halted), 32'd0);

    // Asynchronous reset with the buffer full.
    en            = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk_head("prereset", 32'd2, 32'h102);
    chk("prereset.indx", 32'(bus.indx), 32'd4);
    #2;
    reset_n = 1'b0;
    #1;
    chk_empty("async");
    chk("async.indx", 32'(bus.indx), 32'd0);
    #1;
    reset_n = 1'b1;
    en      = 1'b0;
    tick();
    tick();
    chk_empty("postreset");
    chk("postreset.indx", 32'(bus.indx), 32'd0);
    en = 1'b1;
    tick();
    chk_head("postreset.en", 32'd0, 32'h100);

`ifdef FETCH_HALT_EN
    // Halt word at index 3: words 0..3 delivered, then fetch stops.
    pulse_reset();
    halt_word_en  = 1'b1;
    en            = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk_head("halt3", 32'd3, 32'hD800_0000);
    chk("halt.flag", 32'(halted), 32'd1);
    chk("halt.indx", 32'(bus.indx), 32'd4);
    tick();
    chk_empty("halt.noentry4");
    tick();
    chk_empty("halt.still");
    chk("halt.indx_hold", 32'(bus.indx), 32'd4);
    redirect_valid = 1'b1;
    redirect_pc    = 10'd0;
    tick();
    chk("halt.cleared", 32'(halted), 32'd0);
    redirect_valid = 1'b0;
    tick();
    chk_head("halt.resume", 32'd0, 32'h100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
